// File: rtl/exu_alu_share_arb.sv
// exu_alu_share_arb: round-robin share of one ALU datapath between two requesters,
// with a one-entry registered result buffer and a saturating conflict counter.
module exu_alu_share_arb #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [XLEN-1:0]  req0_op1,
    input  logic [XLEN-1:0]  req0_op2,
    input  logic             req0_add,
    input  logic             req0_lui,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [XLEN-1:0]  req1_op1,
    input  logic [XLEN-1:0]  req1_op2,
    input  logic             req1_add,
    input  logic             req1_lui,
    output logic [XLEN-1:0]  dp_op1,
    output logic [XLEN-1:0]  dp_op2,
    output logic             dp_add,
    output logic             dp_lui,
    input  logic [XLEN-1:0]  dp_res,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [XLEN-1:0]  o_res,
    output logic             o_src,
    output logic [CNT_W-1:0] conflict_cnt
);
    logic             full_q, full_d, rr_q, rr_d, src_q, src_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             can_acc, any, both, gnt, acc;

    always_comb begin
        can_acc    = ~full_q | o_ready;
        any        = req0_valid | req1_valid;
        both       = req0_valid & req1_valid;
        gnt        = both ? rr_q : req1_valid;
        // Ready is also held low while reset is asserted, independent of the clock.
        req0_ready = rst_n & can_acc & any & ~gnt;
        req1_ready = rst_n & can_acc & any & gnt;
        acc        = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        dp_op1     = ~any ? '0 : gnt ? req1_op1 : req0_op1;
        dp_op2     = ~any ? '0 : gnt ? req1_op2 : req0_op2;
        dp_add     = any & (gnt ? req1_add : req0_add);
        dp_lui     = any & (gnt ? req1_lui : req0_lui);
        full_d     = acc | (full_q & ~o_ready);
        res_d      = acc ? dp_res : res_q;
        src_d      = acc ? gnt : src_q;
        rr_d       = acc ? ~gnt : rr_q;
        cnt_d      = (acc & both & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            rr_q   <= 1'b0;
            src_q  <= 1'b0;
            res_q  <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            rr_q   <= rr_d;
            src_q  <= src_d;
            res_q  <= res_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_valid      = full_q;
    assign o_res        = res_q;
    assign o_src        = src_q;
    assign conflict_cnt = cnt_q;
endmodule

// File: tb/tb_exu_alu_share_arb.sv
// tb_exu_alu_share_arb: directed checks of arbitration, buffering, backpressure,
// counter saturation and async reset, with a small ALU datapath model.
module tb_exu_alu_share_arb;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req0_valid, req0_ready, req0_add, req0_lui;
    logic        req1_valid, req1_ready, req1_add, req1_lui;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [31:0] dp_op1, dp_op2, dp_res, o_res;
    logic        dp_add, dp_lui, o_valid, o_ready, o_src;
    logic [3:0]  conflict_cnt;
    int          vectors = 0, miscompares = 0;

    exu_alu_share_arb #(.XLEN(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
        .req0_op2(req0_op2), .req0_add(req0_add), .req0_lui(req0_lui),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
        .req1_op2(req1_op2), .req1_add(req1_add), .req1_lui(req1_lui),
        .dp_op1(dp_op1), .dp_op2(dp_op2), .dp_add(dp_add), .dp_lui(dp_lui),
        .dp_res(dp_res), .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res),
        .o_src(o_src), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Reference datapath: lui passes op2, add sums, otherwise subtract.
    always_comb dp_res = dp_lui ? dp_op2 : dp_add ? dp_op1 + dp_op2 : dp_op1 - dp_op2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ad, input logic lu);
        req0_valid = v; req0_op1 = a; req0_op2 = b; req0_add = ad; req0_lui = lu;
    endtask

    task automatic drv1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic ad, input logic lu);
        req1_valid = v; req1_op1 = a; req1_op2 = b; req1_add = ad; req1_lui = lu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drv0(1'b1, 32'd5, 32'd7, 1'b1, 1'b0);
        drv1(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        o_ready = 1'b0;
        #2;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_res", o_res, 0);
        chk("rst_o_src", o_src, 0);
        chk("rst_cnt", conflict_cnt, 0);
        tick();
        rst_n = 1'b1;
        o_ready = 1'b1;
        #1;
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        chk("t1_dp_res", dp_res, 12);
        chk("t1_o_valid_pre", o_valid, 0);
        tick();
        chk("t1_o_valid", o_valid, 1);
        chk("t1_o_res", o_res, 12);
        chk("t1_o_src", o_src, 0);
        drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drv1(1'b1, 32'd0, 32'h0000_0abc, 1'b0, 1'b1);
        #1;
        chk("t1b_req1_ready", req1_ready, 1);
        chk("t1b_dp_op1", dp_op1, 0);
        tick();
        chk("t1b_o_res", o_res, 32'habc);
        chk("t1b_o_src", o_src, 1);
        drv0(1'b1, 32'd10, 32'd3, 1'b1, 1'b0);
        drv1(1'b1, 32'h1000, 32'h20, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
            chk("t2_req1_ready", req1_ready, (i % 2 == 1) ? 1 : 0);
            tick();
            chk("t2_o_src", o_src, i % 2);
            chk("t2_o_res", o_res, (i % 2 == 0) ? 32'd13 : 32'h1020);
        end
        chk("t2_cnt", conflict_cnt, 4);
        o_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_req0_ready", req0_ready, 0);
            chk("t3_req1_ready", req1_ready, 0);
            tick();
            chk("t3_o_valid", o_valid, 1);
            chk("t3_o_res", o_res, 32'h1020);
            chk("t3_o_src", o_src, 1);
        end
        chk("t3_cnt_hold", conflict_cnt, 4);
        o_ready = 1'b1;
        #1;
        chk("t3_refill_ready", req0_ready, 1);
        tick();
        chk("t3_refill_valid", o_valid, 1);
        chk("t3_refill_res", o_res, 13);
        chk("t3_refill_src", o_src, 0);
        chk("t3_cnt", conflict_cnt, 5);
        drv0(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drv1(1'b1, 32'd0, 32'h100 * i + 1, 1'b0, 1'b1);
            #1;
            chk("t4_req1_ready", req1_ready, 1);
            tick();
            chk("t4_o_valid", o_valid, 1);
            chk("t4_o_res", o_res, 32'h100 * i + 1);
            chk("t4_o_src", o_src, 1);
        end
        drv0(1'b1, 32'd9, 32'd4, 1'b0, 1'b0);
        #1;
        chk("t4_rr_req0_ready", req0_ready, 1);
        chk("t4_rr_req1_ready", req1_ready, 0);
        tick();
        chk("t4_rr_o_res", o_res, 5);
        chk("t4_cnt", conflict_cnt, 6);
        for (int i = 0; i < 20; i++) tick();
        chk("t5_cnt_sat", conflict_cnt, 15);
        chk("t5_o_valid", o_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_o_valid_async", o_valid, 0);
        chk("t6_o_res_async", o_res, 0);
        chk("t6_cnt_async", conflict_cnt, 0);
        chk("t6_req0_ready_rst", req0_ready, 0);
        chk("t6_req1_ready_rst", req1_ready, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6_req0_ready", req0_ready, 1);
        chk("t6_req1_ready", req1_ready, 0);
        tick();
        chk("t6_o_src", o_src, 0);
        chk("t6_o_res", o_res, 5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
